// File: rtl/ffe_sample_feeder.sv
// ffe_sample_feeder: buffers upstream samples in a small FIFO and presents
// them to the FFE at a fixed cadence. When the FIFO runs dry it injects a
// zero sample, so the FFE schedule never stalls.
module ffe_sample_feeder #(
  parameter int IN_OUT_BUS_WIDTH  = 12,
  parameter int FIFO_DEPTH        = 4,
  parameter int CYCLES_PER_SAMPLE = 5,
  parameter int PRIME_LEVEL       = 2
) (
  input  logic                               ffe_clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic signed [IN_OUT_BUS_WIDTH-1:0] s_data,
  output logic                               load,
  output logic signed [IN_OUT_BUS_WIDTH-1:0] d_in,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic                               underrun,
  input  logic                               clr_underrun,
  output logic [7:0]                         underrun_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (CYCLES_PER_SAMPLE > 2) ? $clog2(CYCLES_PER_SAMPLE) : 1;

  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LEVEL);
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES_PER_SAMPLE - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                             r_state;
  state_t                             w_next;
  logic [CW-1:0]                      r_cnt;
  logic [AW-1:0]                      r_wptr;
  logic [AW-1:0]                      r_rptr;
  logic [LW-1:0]                      r_level;
  logic signed [IN_OUT_BUS_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                               r_load;
  logic signed [IN_OUT_BUS_WIDTH-1:0] r_d_in;
  logic                               r_underrun;
  logic [7:0]                         r_ur_cnt;

  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_tick;

  // s_ready only looks at occupancy: a full FIFO refuses data even if a
  // pop happens in the same cycle, so there is no pass-through path.
  assign s_ready      = rst && (r_level < DEPTH_L);
  assign w_empty      = (r_level == '0);
  assign w_push       = s_valid && s_ready;
  assign w_tick       = (r_state == RUN) && (r_cnt == CNT_MAX);
  assign w_pop        = w_tick && !w_empty;

  assign fifo_level   = r_level;
  assign load         = r_load;
  assign d_in         = r_d_in;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_ur_cnt;

  // State register
  always_ff @(posedge ffe_clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; dropping enable returns to IDLE from any state
  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = PRIME;
        PRIME:   if (r_level >= PRIME_L) w_next = RUN;
        RUN:     w_next = RUN;
        default: w_next = IDLE;
      endcase
    end
  end

  // Cadence counter: primed to the tick value so the first emission is immediate
  always_ff @(posedge ffe_clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == PRIME && w_next == RUN) begin
      r_cnt <= CNT_MAX;
    end else if (r_state == RUN) begin
      r_cnt <= (r_cnt == '0) ? CNT_MAX : r_cnt - 1'b1;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge ffe_clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage; contents need no reset because occupancy is cleared
  always_ff @(posedge ffe_clk) begin
    if (w_push) r_mem[r_wptr] <= s_data;
  end

  // Emission: strobe plus head sample, or a zero sample when starved
  always_ff @(posedge ffe_clk) begin
    if (!rst) begin
      r_load <= 1'b0;
      r_d_in <= '0;
    end else if (w_tick) begin
      r_load <= 1'b1;
      r_d_in <= w_empty ? '0 : r_mem[r_rptr];
    end else begin
      r_load <= 1'b0;
    end
  end

  // Underrun flag and saturating count; a new underrun beats a clear
  always_ff @(posedge ffe_clk) begin
    if (!rst) begin
      r_underrun <= 1'b0;
      r_ur_cnt   <= '0;
    end else if (w_tick && w_empty) begin
      r_underrun <= 1'b1;
      if (r_ur_cnt != 8'hFF) r_ur_cnt <= r_ur_cnt + 1'b1;
    end else if (clr_underrun) begin
      r_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ffe_sample_feeder.sv
// Directed bench for ffe_sample_feeder: a per-cycle vector table for the main
// flow, then hand-written sequences for reset glitches, saturation and
// enable drop on a tick edge.
module tb_ffe_sample_feeder;

  logic        ffe_clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [11:0] s_data = '0;
  logic        load;
  logic [11:0] d_in;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic        clr_underrun = 1'b0;
  logic [7:0]  underrun_cnt;

  int n_pass = 0;
  int n_total = 0;

  ffe_sample_feeder dut (
    .ffe_clk      (ffe_clk),
    .rst          (rst),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .load         (load),
    .d_in         (d_in),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .clr_underrun (clr_underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 ffe_clk = ~ffe_clk;

  typedef struct {
    logic        rst, en, vld;
    logic [11:0] data;
    logic        clr;
    logic        load;
    logic [11:0] d;
    logic [2:0]  lev;
    logic        rdy, ur;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int n, input logic r, input logic e, input logic v,
                     input logic [11:0] dat, input logic c, input logic ld,
                     input logic [11:0] dd, input logic [2:0] lv, input logic rd,
                     input logic u, input logic [7:0] cn);
    vec_t t;
    t.rst = r; t.en = e; t.vld = v; t.data = dat; t.clr = c;
    t.load = ld; t.d = dd; t.lev = lv; t.rdy = rd; t.ur = u; t.cnt = cn;
    for (int k = 0; k < n; k++) vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge ffe_clk);
    #1;
  endtask

  initial begin
    int nloads;
    int last;
    int bad_gap;
    int stray;

    //   n  rst en vld data    clr | load d_in    lev rdy ur cnt
    add(1, 0, 0, 0, 12'h000, 0,  0, 12'h000, 0, 0, 0, 0);
    add(1, 1, 0, 1, 12'h001, 0,  0, 12'h000, 1, 1, 0, 0);
    add(1, 1, 0, 1, 12'h7FF, 0,  0, 12'h000, 2, 1, 0, 0);
    add(1, 1, 0, 1, 12'h800, 0,  0, 12'h000, 3, 1, 0, 0);
    add(1, 1, 0, 1, 12'hFFF, 0,  0, 12'h000, 4, 0, 0, 0);
    add(2, 1, 0, 1, 12'h123, 0,  0, 12'h000, 4, 0, 0, 0);
    add(2, 1, 1, 1, 12'h123, 0,  0, 12'h000, 4, 0, 0, 0);
    add(1, 1, 1, 1, 12'h123, 0,  1, 12'h001, 3, 1, 0, 0);
    add(1, 1, 1, 1, 12'h123, 0,  0, 12'h001, 4, 0, 0, 0);
    add(3, 1, 1, 0, 12'h000, 0,  0, 12'h001, 4, 0, 0, 0);
    add(1, 1, 1, 0, 12'h000, 0,  1, 12'h7FF, 3, 1, 0, 0);
    add(4, 1, 1, 0, 12'h000, 0,  0, 12'h7FF, 3, 1, 0, 0);
    add(1, 1, 1, 0, 12'h000, 0,  1, 12'h800, 2, 1, 0, 0);
    add(4, 1, 1, 0, 12'h000, 0,  0, 12'h800, 2, 1, 0, 0);
    add(1, 1, 1, 0, 12'h000, 0,  1, 12'hFFF, 1, 1, 0, 0);
    add(4, 1, 1, 0, 12'h000, 0,  0, 12'hFFF, 1, 1, 0, 0);
    add(1, 1, 1, 0, 12'h000, 0,  1, 12'h123, 0, 1, 0, 0);
    add(4, 1, 1, 0, 12'h000, 0,  0, 12'h123, 0, 1, 0, 0);
    add(1, 1, 1, 0, 12'h000, 0,  1, 12'h000, 0, 1, 1, 1);
    add(4, 1, 1, 0, 12'h000, 0,  0, 12'h000, 0, 1, 1, 1);
    add(1, 1, 1, 1, 12'h2AB, 0,  1, 12'h000, 1, 1, 1, 2);
    add(1, 1, 1, 0, 12'h000, 1,  0, 12'h000, 1, 1, 0, 2);
    add(3, 1, 1, 0, 12'h000, 0,  0, 12'h000, 1, 1, 0, 2);
    add(1, 1, 1, 0, 12'h000, 0,  1, 12'h2AB, 0, 1, 0, 2);
    add(1, 1, 0, 1, 12'h055, 0,  0, 12'h2AB, 1, 1, 0, 2);
    add(2, 1, 1, 0, 12'h000, 0,  0, 12'h2AB, 1, 1, 0, 2);
    add(1, 1, 1, 1, 12'h0AA, 0,  0, 12'h2AB, 2, 1, 0, 2);
    add(1, 1, 1, 0, 12'h000, 0,  0, 12'h2AB, 2, 1, 0, 2);
    add(1, 1, 1, 0, 12'h000, 0,  1, 12'h055, 1, 1, 0, 2);
    add(1, 1, 1, 1, 12'h100, 0,  0, 12'h055, 2, 1, 0, 2);
    add(1, 1, 1, 1, 12'h200, 0,  0, 12'h055, 3, 1, 0, 2);
    add(1, 0, 1, 0, 12'h000, 0,  0, 12'h000, 0, 0, 0, 0);
    add(1, 1, 0, 0, 12'h000, 0,  0, 12'h000, 0, 1, 0, 0);

    #1;
    foreach (vq[i]) begin
      rst = vq[i].rst; enable = vq[i].en; s_valid = vq[i].vld;
      s_data = vq[i].data; clr_underrun = vq[i].clr;
      step();
      chk($sformatf("row%0d.load", i), 32'(load), 32'(vq[i].load));
      chk($sformatf("row%0d.d_in", i), 32'(d_in), 32'(vq[i].d));
      chk($sformatf("row%0d.level", i), 32'(fifo_level), 32'(vq[i].lev));
      chk($sformatf("row%0d.s_ready", i), 32'(s_ready), 32'(vq[i].rdy));
      chk($sformatf("row%0d.underrun", i), 32'(underrun), 32'(vq[i].ur));
      chk($sformatf("row%0d.ur_cnt", i), 32'(underrun_cnt), 32'(vq[i].cnt));
    end

    // Buffer two samples, then glitch rst low between edges
    clr_underrun = 1'b0; enable = 1'b0;
    s_valid = 1'b1; s_data = 12'h3C3; step();
    s_data = 12'h0F0; step();
    s_valid = 1'b0;
    rst = 1'b0;
    #3;
    chk("glitch.s_ready_low", 32'(s_ready), 32'd0);
    rst = 1'b1;
    step();
    chk("glitch.level_kept", 32'(fifo_level), 32'd2);
    chk("glitch.s_ready", 32'(s_ready), 32'd1);

    // Run until the underrun count must have saturated
    enable = 1'b1;
    nloads = 0; last = 0; bad_gap = 0;
    for (int cyc = 0; cyc < 2000 && nloads < 258; cyc++) begin
      step();
      if (load) begin
        nloads++;
        if (nloads == 1) chk("sat.first_d", 32'(d_in), 32'h3C3);
        if (nloads == 2) chk("sat.second_d", 32'(d_in), 32'h0F0);
        if (nloads == 3) chk("sat.third_d_zero", 32'(d_in), 32'h000);
        if (nloads > 1 && (cyc - last) != 5) bad_gap++;
        last = cyc;
      end
    end
    chk("sat.load_count", 32'(nloads), 32'd258);
    chk("sat.gap_errors", 32'(bad_gap), 32'd0);
    chk("sat.ur_cnt", 32'(underrun_cnt), 32'd255);
    chk("sat.underrun", 32'(underrun), 32'd1);

    // Drop enable during a tick cycle: that emission must still happen
    repeat (4) step();
    enable = 1'b0;
    step();
    chk("drop.load", 32'(load), 32'd1);
    chk("drop.d_in", 32'(d_in), 32'd0);
    chk("drop.ur_cnt_held", 32'(underrun_cnt), 32'd255);
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (load) stray++;
    end
    chk("drop.no_more_loads", 32'(stray), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
